// File: rtl/inc_seq_gen_if.sv
// Output stream of the 4-bit sequence generator: valid/ready handshake
// carrying the current sequence value and a final-beat marker.
interface inc_seq_gen_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // Producer side: the generator drives the beat and watches ready.
  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Consumer side: accepts beats and applies backpressure.
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/inc_seq_gen.sv
// 4-bit stepped sequence generator built around the add-by-one incrementer.
// A start request in IDLE captures start/end values and the wrap mode; every
// value from start to end is then offered on the output stream, one beat per
// accepted handshake. Carry out of 15 either wraps to 0 or aborts the run
// with a sticky overflow flag.

// Plain 4-bit incrementer: out = in1 + cin, cout = carry out of bit 3.
module add_by_one (
  input  logic [3:0] in1,
  input  logic       cin,
  output logic [3:0] out,
  output logic       cout
);
  assign {cout, out} = {1'b0, in1} + {4'b0000, cin};
endmodule

module inc_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   start_val,
  input  logic [WIDTH-1:0]   end_val,
  input  logic               wrap,
  inc_seq_gen_if.master      os,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] end_r;
  logic             wrap_r;
  logic             ovf_r;

  logic [WIDTH-1:0] inc_s;
  logic             carry_s;
  logic             last_s;
  logic             hs_s;

  // Successor value and carry always come from the shared incrementer.
  add_by_one u_inc (
    .in1  (count_r),
    .cin  (1'b1),
    .out  (inc_s),
    .cout (carry_s)
  );

  assign last_s = (count_r == end_r);
  // Handshake is qualified by state, not by the out_valid port, so that the
  // ready input never feeds back into the valid decode.
  assign hs_s   = (state_r == EMIT) && os.out_ready;

  // State register; synchronous reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode: leave EMIT only on a handshake of the last beat or on
  // an overflow that is not allowed to wrap; DONE lasts exactly one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = EMIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT: begin
        if (hs_s && (last_s || (carry_s && !wrap_r))) begin
          next_state_s = DONE;
        end else begin
          next_state_s = EMIT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Datapath registers: capture the run parameters on an accepted start and
  // advance the count only on a handshake that is not the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 4'd0;
      end_r   <= 4'd0;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            count_r <= start_val;
            end_r   <= end_val;
            wrap_r  <= wrap;
            ovf_r   <= 1'b0;
          end
        end
        EMIT: begin
          if (hs_s && !last_s) begin
            if (!carry_s) begin
              count_r <= inc_s;
            end else if (wrap_r) begin
              count_r <= 4'd0;
            end else begin
              ovf_r   <= 1'b1;
            end
          end
        end
        DONE: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Output decode from state and registers only.
  always_comb begin
    os.out_valid = 1'b0;
    os.out_data  = 4'd0;
    os.out_last  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    ovf          = ovf_r;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      EMIT: begin
        os.out_valid = 1'b1;
        os.out_data  = count_r;
        os.out_last  = last_s;
        busy         = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
